// File: rtl/pipe_responder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_responder
// Brief    : Responder end of the pipelined valid/ready request/response bus.
//            Serves reads and writes from a local register array. Returns one
//            in-order response per request through a 2-entry response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_responder #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 16,
    parameter int N_REGS = 8
) (
    input  logic              i_clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic [W_DATA-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        o_err_cnt
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    // One extra bit so N_REGS == 2^(W_ADDR-2) is representable
    localparam logic [W_ADDR-2:0] C_NREGS = (W_ADDR-1)'(N_REGS);

    logic [W_DATA-1:0] regs_q      [N_REGS];
    logic [W_DATA-1:0] fifo_data_q [2];
    logic [1:0]        fifo_err_q;
    logic              wptr_q;
    logic              rptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [7:0]        err_cnt_q;
    logic [7:0]        err_cnt_d;

    logic [W_ADDR-3:0] w_index;
    logic [IDX_W-1:0]  w_sel;
    logic              w_legal;
    logic              w_accept;
    logic              w_pop;
    logic              w_wr_en;
    logic [W_DATA-1:0] w_rsp_data;
    logic              w_rsp_err;

    // Handshake flags and outputs; ready depends only on registered count
    always_comb begin
        req_ready = resetn && (count_q < 2'd2);
        rsp_valid = (count_q != 2'd0);
        rsp_rdata = fifo_data_q[rptr_q];
        rsp_err   = fifo_err_q[rptr_q];
        o_err_cnt = err_cnt_q;
        w_accept  = req_valid && req_ready;
        w_pop     = rsp_valid && rsp_ready;
    end

    // Address decode and response formation for the request on the bus
    always_comb begin
        w_index    = req_addr[W_ADDR-1:2];
        w_sel      = w_index[IDX_W-1:0];
        w_legal    = (req_addr[1:0] == 2'b00) && ({1'b0, w_index} < C_NREGS);
        w_wr_en    = w_accept && w_legal && req_we;
        w_rsp_err  = !w_legal;
        // Register value before this edge, so a same-edge write is not visible
        w_rsp_data = (w_legal && !req_we) ? regs_q[w_sel] : '0;
    end

    // Next occupancy and saturating error count
    always_comb begin
        count_d = count_q;
        case ({w_accept, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        err_cnt_d = err_cnt_q;
        if (w_accept && !w_legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Register array: legal writes land at the accept edge
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[w_sel] <= req_wdata;
        end
    end

    // Response FIFO: push at accept, pop on head handshake, pointers wrap mod 2
    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_err_q <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            if (w_accept) begin
                fifo_data_q[wptr_q] <= w_rsp_data;
                fifo_err_q[wptr_q]  <= w_rsp_err;
                wptr_q              <= ~wptr_q;
            end
            if (w_pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_responder
// Brief    : Self-checking bench for pipe_responder. A queue-based model of
//            the responder is compared with the DUT on every falling edge;
//            directed sequences add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_responder;

    localparam int W_DATA = 32;
    localparam int W_ADDR = 16;
    localparam int N_REGS = 8;

    logic              i_clk;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [W_ADDR-1:0] req_addr;
    logic [W_DATA-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W_DATA-1:0] rsp_rdata;
    logic              rsp_err;
    logic [7:0]        o_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_responder #(
        .W_DATA (W_DATA),
        .W_ADDR (W_ADDR),
        .N_REGS (N_REGS)
    ) u_dut (
        .i_clk     (i_clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .o_err_cnt (o_err_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [W_DATA-1:0] data;
        logic              err;
    } rsp_t;

    logic [W_DATA-1:0] m_regs [N_REGS];
    rsp_t              m_q [$];
    int                m_err = 0;

    always @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_err = 0;
            for (int i = 0; i < N_REGS; i++) m_regs[i] = '0;
        end else begin
            automatic bit   acc = req_valid && (m_q.size() < 2);
            automatic bit   pop = (m_q.size() != 0) && rsp_ready;
            automatic int   idx = int'(req_addr) / 4;
            automatic bit   legal = (req_addr % 4 == 0) && (idx < N_REGS);
            automatic rsp_t r;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                r.data = '0;
                r.err  = !legal;
                if (!legal) begin
                    if (m_err < 255) m_err = m_err + 1;
                end else if (req_we) begin
                    m_regs[idx] = req_wdata;
                end else begin
                    r.data = m_regs[idx];
                end
                m_q.push_back(r);
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge i_clk) begin
        check("cmp_req_ready", 32'(req_ready), 32'(resetn === 1'b1 && m_q.size() < 2));
        check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_q.size() != 0));
        check("cmp_err_cnt", 32'(o_err_cnt), 32'(m_err));
        if (m_q.size() != 0) begin
            check("cmp_rsp_rdata", rsp_rdata, m_q[0].data);
            check("cmp_rsp_err", 32'(rsp_err), 32'(m_q[0].err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [W_ADDR-1:0] a,
                         input logic [W_DATA-1:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        resetn    = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFF);

        // Reset held with a request offered: nothing accepted
        repeat (3) begin
            tick();
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        resetn = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_errcnt", 32'(o_err_cnt), 32'd0);
        tick();
        check("post_rst_idle_valid", 32'(rsp_valid), 32'd0);

        // Write then read-back of 0x0008
        drive(1'b1, 1'b1, 16'h0008, 32'hDEAD_BEEF);
        tick();
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        drive(1'b1, 1'b0, 16'h0008, 32'h0);
        tick();
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        tick();
        check("rd_drained", 32'(rsp_valid), 32'd0);

        // Decode errors: misaligned, then out of range
        drive(1'b1, 1'b0, 16'h0002, 32'h0);
        tick();
        check("mis_err", 32'(rsp_err), 32'd1);
        check("mis_rdata", rsp_rdata, 32'd0);
        drive(1'b1, 1'b0, 16'h0020, 32'h0);
        tick();
        check("oor_err", 32'(rsp_err), 32'd1);
        check("oor_rdata", rsp_rdata, 32'd0);
        check("oor_errcnt", 32'(o_err_cnt), 32'd2);
        drive(1'b1, 1'b0, 16'h0000, 32'h0);
        tick();
        check("no_side_rdata", rsp_rdata, 32'd0);
        check("no_side_err", 32'(rsp_err), 32'd0);
        check("no_side_errcnt", 32'(o_err_cnt), 32'd2);

        // Preload 1,2,3 at 0x0,0x4,0x8
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'(4 * i), 32'(i + 1));
            tick();
        end
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        tick();

        // Backpressure
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 32'h0);
        tick();
        check("bp1_ready", 32'(req_ready), 32'd1);
        check("bp1_rdata", rsp_rdata, 32'd1);
        drive(1'b1, 1'b0, 16'h0004, 32'h0);
        tick();
        check("bp2_ready", 32'(req_ready), 32'd0);
        check("bp2_rdata", rsp_rdata, 32'd1);
        drive(1'b1, 1'b0, 16'h0008, 32'h0);
        repeat (2) begin
            tick();
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_rdata", rsp_rdata, 32'd1);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_pop_rdata", rsp_rdata, 32'd2);
        check("bp_pop_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;
        tick();
        check("bp3_acc_ready", 32'(req_ready), 32'd0);
        check("bp3_acc_rdata", rsp_rdata, 32'd2);
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        rsp_ready = 1'b1;
        tick();
        check("bp_last_rdata", rsp_rdata, 32'd3);
        tick();
        check("bp_empty", 32'(rsp_valid), 32'd0);

        // Simultaneous push and pop at count 1
        drive(1'b1, 1'b0, 16'h0000, 32'h0);
        tick();
        drive(1'b1, 1'b0, 16'h0004, 32'h0);
        tick();
        check("pp_valid", 32'(rsp_valid), 32'd1);
        check("pp_ready", 32'(req_ready), 32'd1);
        check("pp_rdata", rsp_rdata, 32'd2);
        drive(1'b1, 1'b0, 16'h0008, 32'h0);
        tick();
        check("pp_next_rdata", rsp_rdata, 32'd3);
        check("pp_next_valid", 32'(rsp_valid), 32'd1);
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        tick();

        // Mid-operation asynchronous reset with two queued responses
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 32'h0);
        tick();
        drive(1'b1, 1'b0, 16'h0004, 32'h0);
        tick();
        check("mid_full_ready", 32'(req_ready), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        resetn    = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'(4 * i), 32'h0);
            tick();
            check("mid_rst_reg_clear", rsp_rdata, 32'd0);
            check("mid_rst_reg_valid", 32'(rsp_valid), 32'd1);
        end

        // Error counter saturation with back-to-back misaligned reads
        drive(1'b1, 1'b0, 16'h0001, 32'h0);
        repeat (254) tick();
        check("sat_254", 32'(o_err_cnt), 32'd254);
        repeat (2) tick();
        check("sat_255", 32'(o_err_cnt), 32'd255);
        repeat (44) tick();
        check("sat_300", 32'(o_err_cnt), 32'd255);
        drive(1'b0, 1'b0, 16'h0000, 32'h0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
